// File: rtl/light_sequencer.sv
// ---------------------------------------------------------------------------
// light_sequencer
//   Steps NUM_LIGHTS lamp outputs through one of four patterns (fill, chase,
//   bounce, blink). The step rate is set by an internal prescaler.
//   The optional direction input is enabled by defining LIGHT_SEQ_DIR_EN.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   on         in   run enable (level)
//   mode       in   pattern: 00 fill, 01 chase, 10 bounce, 11 blink
//   div        in   step period minus one, in clk cycles
//   dir        in   (LIGHT_SEQ_DIR_EN only) 1 = mirror the pattern bit-wise
//   lights     out  registered lamp drive, bit 0 = first lamp
//   step_pulse out  one-cycle strobe on every tick-driven lights update
//   wrap       out  one-cycle strobe on the tick that returns to position 0
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | lamps dark, waiting for on
// RUN   | prescaler counting, pattern advancing on each tick
// ---------------------------------------------------------------------------
module light_sequencer #(
    parameter int NUM_LIGHTS = 3,
    parameter int DIV_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  on,
    input  logic [1:0]            mode,
    input  logic [DIV_W-1:0]      div,
`ifdef LIGHT_SEQ_DIR_EN
    input  logic                  dir,
`endif
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  step_pulse,
    output logic                  wrap
);

    localparam int POS_W = $clog2(2 * NUM_LIGHTS - 2);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [POS_W-1:0]        pos_q, pos_d, pos_nx;
    logic [2:0]              cfg_q, cfg_d;      // {dir, mode} latched together
    logic [2:0]              cfg_in;
    logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
    logic                    step_q, step_d;
    logic                    wrap_q, wrap_d;
    logic                    dir_in;

`ifdef LIGHT_SEQ_DIR_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    assign cfg_in = {dir_in, mode};

    function automatic logic [NUM_LIGHTS-1:0] pattern(input logic [2:0] cfg,
                                                      input logic [POS_W-1:0] pos);
        int                    p;
        int                    idx;
        logic [NUM_LIGHTS-1:0] pat;
        logic [NUM_LIGHTS-1:0] rev;
        p   = int'(pos);
        // bounce runs back down after the top lamp without repeating it
        idx = (p < NUM_LIGHTS) ? p : (2 * NUM_LIGHTS - 2 - p);
        pat = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            case (cfg[1:0])
                2'b00:   pat[i] = (i <= p);
                2'b01:   pat[i] = (i == p);
                2'b10:   pat[i] = (i == idx);
                default: pat[i] = (p == 0);
            endcase
        end
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            rev[i] = pat[NUM_LIGHTS-1-i];
        end
        return cfg[2] ? rev : pat;
    endfunction

    function automatic logic [POS_W-1:0] next_pos(input logic [2:0] cfg,
                                                  input logic [POS_W-1:0] pos);
        int per;
        case (cfg[1:0])
            2'b10:   per = 2 * NUM_LIGHTS - 2;
            2'b11:   per = 2;
            default: per = NUM_LIGHTS;
        endcase
        return (int'(pos) == per - 1) ? '0 : pos + 1'b1;
    endfunction

    assign pos_nx = next_pos(cfg_q, pos_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        cfg_d    = cfg_q;
        lights_d = lights_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                lights_d = '0;
                cnt_d    = '0;
                pos_d    = '0;
                if (on) begin
                    state_d  = RUN;
                    cfg_d    = cfg_in;
                    lights_d = pattern(cfg_in, '0);
                end
            end
            RUN: begin
                if (!on) begin
                    // dropping on beats a coincident tick: no strobes
                    state_d  = IDLE;
                    lights_d = '0;
                    cnt_d    = '0;
                    pos_d    = '0;
                end else if (cnt_q >= div) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                    if (cfg_in != cfg_q) begin
                        cfg_d    = cfg_in;
                        pos_d    = '0;
                        lights_d = pattern(cfg_in, '0);
                    end else begin
                        pos_d    = pos_nx;
                        lights_d = pattern(cfg_q, pos_nx);
                        wrap_d   = (pos_nx == '0);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pos_q    <= '0;
            cfg_q    <= '0;
            lights_q <= '0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            cfg_q    <= cfg_d;
            lights_q <= lights_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
        end
    end

    assign lights     = lights_q;
    assign step_pulse = step_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_light_sequencer.sv
// ---------------------------------------------------------------------------
// tb_light_sequencer
//   Directed bench for light_sequencer. u3 is a 3-lamp instance used for fill,
//   chase, blink, mode change, divider change and reset; u4 is a 4-lamp
//   instance used for the bounce pattern with div=2.
// ---------------------------------------------------------------------------
module tb_light_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        on3, on4;
    logic [1:0]  mode3, mode4;
    logic [23:0] div3, div4;
    logic [2:0]  lights3;
    logic [3:0]  lights4;
    logic        sp3, wr3, sp4, wr4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    light_sequencer #(.NUM_LIGHTS(3), .DIV_W(24)) u3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .on         (on3),
        .mode       (mode3),
        .div        (div3),
`ifdef LIGHT_SEQ_DIR_EN
        .dir        (1'b0),
`endif
        .lights     (lights3),
        .step_pulse (sp3),
        .wrap       (wr3)
    );

    light_sequencer #(.NUM_LIGHTS(4), .DIV_W(24)) u4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .on         (on4),
        .mode       (mode4),
        .div        (div4),
`ifdef LIGHT_SEQ_DIR_EN
        .dir        (1'b0),
`endif
        .lights     (lights4),
        .step_pulse (sp4),
        .wrap       (wr4)
    );

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] l, input logic s, input logic w);
        chk({tag, ".lights"}, 16'(lights3), 16'(l));
        chk({tag, ".step"},   16'(sp3),     16'(s));
        chk({tag, ".wrap"},   16'(wr3),     16'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fill_l [4];
        logic       fill_w [4];
        logic [3:0] bnc    [6];
        fill_l = '{3'b011, 3'b111, 3'b001, 3'b011};
        fill_w = '{1'b0,   1'b0,   1'b1,   1'b0};
        bnc    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

        rst_n = 1'b0;
        on3 = 1'b0; mode3 = 2'b00; div3 = 24'd0;
        on4 = 1'b0; mode4 = 2'b10; div4 = 24'd2;
        step(2);
        chk3("reset", 3'b000, 1'b0, 1'b0);
        chk("reset.u4", 16'(lights4), 16'h0);

        // fill, div=0
        rst_n = 1'b1;
        on3   = 1'b1;
        chk("fill.pre", 16'(lights3), 16'h0);
        step();
        chk3("fill.entry", 3'b001, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk3($sformatf("fill.%0d", k), fill_l[k], 1'b1, fill_w[k]);
        end

        // chase, stop mid-pattern, restart at position 0
        on3 = 1'b0;
        step();
        chk3("chase.idle", 3'b000, 1'b0, 1'b0);
        mode3 = 2'b01;
        on3   = 1'b1;
        step();
        chk3("chase.entry", 3'b001, 1'b0, 1'b0);
        step();
        chk3("chase.p1", 3'b010, 1'b1, 1'b0);
        on3 = 1'b0;
        step();
        chk3("chase.off", 3'b000, 1'b0, 1'b0);
        step();
        chk3("chase.off2", 3'b000, 1'b0, 1'b0);
        on3 = 1'b1;
        step();
        chk3("chase.restart", 3'b001, 1'b0, 1'b0);
        on3 = 1'b0;

        // bounce on 4 lamps, div=2
        on4 = 1'b1;
        step();
        chk("bnc.entry", 16'(lights4), 16'h1);
        chk("bnc.entry.step", 16'(sp4), 16'h0);
        for (int k = 1; k <= 18; k++) begin
            step();
            chk($sformatf("bnc.%0d.lights", k), 16'(lights4), 16'(bnc[(k / 3) % 6]));
            chk($sformatf("bnc.%0d.step", k),   16'(sp4),     16'(k % 3 == 0));
            chk($sformatf("bnc.%0d.wrap", k),   16'(wr4),     16'(k == 18));
        end
        on4 = 1'b0;

        // fill with div=9, switch to blink mid-hold
        div3  = 24'd9;
        mode3 = 2'b00;
        on3   = 1'b1;
        step();
        chk3("mc.entry", 3'b001, 1'b0, 1'b0);
        step(3);
        mode3 = 2'b11;
        step(6);
        chk3("mc.hold", 3'b001, 1'b0, 1'b0);
        step();
        chk3("mc.switch", 3'b111, 1'b1, 1'b0);
        step(9);
        chk3("mc.hold2", 3'b111, 1'b0, 1'b0);
        step();
        chk3("mc.blink1", 3'b000, 1'b1, 1'b0);
        step(10);
        chk3("mc.blink0", 3'b111, 1'b1, 1'b1);

        // lowering div mid-count takes effect at once
        on3 = 1'b0;
        step();
        div3  = 24'd100;
        mode3 = 2'b00;
        on3   = 1'b1;
        step();
        chk3("div.entry", 3'b001, 1'b0, 1'b0);
        step(50);
        chk3("div.cnt50", 3'b001, 1'b0, 1'b0);
        div3 = 24'd10;
        step();
        chk3("div.tick", 3'b011, 1'b1, 1'b0);
        step(10);
        chk3("div.hold", 3'b011, 1'b0, 1'b0);
        step();
        chk3("div.tick2", 3'b111, 1'b1, 1'b0);

        // reset while running with on held high
        rst_n = 1'b0;
        step();
        chk3("rst.run", 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk3("rst.entry", 3'b001, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
